// File: rtl/cool_attn_pkg.sv
// rtl/cool_attn_pkg.sv - shared types and helpers for the serial add scheduler
package cool_attn_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Requester ID width; a single requester still needs one bit of ID.
    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/serial_add_sched_if.sv
// rtl/serial_add_sched_if.sv - request/response bus; req_sub exists only under SERIAL_ADD_SUB_EN
interface serial_add_sched_if
    import cool_attn_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int NREQ  = 4
);
    localparam int IDW = id_width(NREQ);

    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ*WIDTH-1:0] req_a;
    logic [NREQ*WIDTH-1:0] req_b;
`ifdef SERIAL_ADD_SUB_EN
    logic [NREQ-1:0]       req_sub;
`endif
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [IDW-1:0]        rsp_id;
    logic [WIDTH-1:0]      rsp_sum;
    logic                  rsp_cout;
    logic                  busy;

    modport master (
`ifdef SERIAL_ADD_SUB_EN
        output req_sub,
`endif
        output req_valid, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_sum, rsp_cout, busy
    );

    modport slave (
`ifdef SERIAL_ADD_SUB_EN
        input  req_sub,
`endif
        input  req_valid, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_sum, rsp_cout, busy
    );

endinterface

// File: rtl/serial_add_core.sv
// rtl/serial_add_core.sv - 1-bit full adder with carry flop, shared by all requesters
module serial_add_core (
    input  logic clk,
    input  logic rst_n,
    input  logic ebl,
    input  logic clr,
    input  logic cin_init,
    input  logic a_in,
    input  logic b_in,
    output logic sum,
    output logic carry
);

    assign sum = a_in ^ b_in ^ carry;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            carry <= 1'b0;
        end else if (clr) begin
            carry <= cin_init;
        end else if (ebl) begin
            carry <= (a_in & b_in) | (a_in & carry) | (b_in & carry);
        end
    end

endmodule

// File: rtl/serial_add_sched.sv
// rtl/serial_add_sched.sv - round-robin scheduler over one bit-serial adder; subtract mode under SERIAL_ADD_SUB_EN
module serial_add_sched
    import cool_attn_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int NREQ  = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    serial_add_sched_if.slave  bus
);
    localparam int IDW = id_width(NREQ);
    localparam int CW  = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    state_t           state, state_nxt;
    logic [IDW-1:0]   ptr, id_q, gid;
    logic [NREQ-1:0]  grant;
    logic             found;
    int               idx;
    logic [WIDTH-1:0] a_sh, b_sh, res_sh;
    logic [CW-1:0]    cnt;
    logic             accept, last_bit, sub_sel;
    logic             core_sum, core_carry;

    // Search starts just after the last granted requester.
    always_comb begin
        grant = '0;
        gid   = '0;
        found = 1'b0;
        idx   = 0;
        for (int k = 1; k <= NREQ; k++) begin
            idx = (int'(ptr) + k) % NREQ;
            if (!found && bus.req_valid[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                gid        = IDW'(idx);
            end
        end
    end

    assign accept        = (state == IDLE) && found;
    assign bus.req_ready = (state == IDLE) ? grant : '0;
    assign last_bit      = (cnt == CW'(WIDTH - 1));

`ifdef SERIAL_ADD_SUB_EN
    assign sub_sel = bus.req_sub[gid];
`else
    assign sub_sel = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept)        state_nxt = SHIFT;
            SHIFT:   if (last_bit)      state_nxt = DONE;
            DONE:    if (bus.rsp_ready) state_nxt = IDLE;
            default:                    state_nxt = IDLE;
        endcase
    end

    // Subtraction is A + ~B + 1: invert B here, the core presets carry to 1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh   <= '0;
            b_sh   <= '0;
            res_sh <= '0;
            cnt    <= '0;
            id_q   <= '0;
            ptr    <= IDW'(NREQ - 1);
        end else if (accept) begin
            a_sh <= bus.req_a[int'(gid)*WIDTH +: WIDTH];
            b_sh <= bus.req_b[int'(gid)*WIDTH +: WIDTH] ^ {WIDTH{sub_sel}};
            id_q <= gid;
            ptr  <= gid;
            cnt  <= '0;
        end else if (state == SHIFT) begin
            a_sh   <= a_sh >> 1;
            b_sh   <= b_sh >> 1;
            res_sh <= {core_sum, res_sh[WIDTH-1:1]};
            cnt    <= cnt + CW'(1);
        end
    end

    serial_add_core u_core (
        .clk      (clk),
        .rst_n    (rst_n),
        .ebl      (state == SHIFT),
        .clr      (accept),
        .cin_init (sub_sel),
        .a_in     (a_sh[0]),
        .b_in     (b_sh[0]),
        .sum      (core_sum),
        .carry    (core_carry)
    );

    assign bus.rsp_valid = (state == DONE);
    assign bus.rsp_sum   = res_sh;
    assign bus.rsp_cout  = core_carry;
    assign bus.rsp_id    = id_q;
    assign bus.busy      = (state != IDLE);

endmodule

// File: tb/tb_serial_add_sched.sv
// tb/tb_serial_add_sched.sv - randomized and directed bench against a transaction-level model
module tb_serial_add_sched;
    localparam int W = 8;
    localparam int N = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    serial_add_sched_if #(.WIDTH(W), .NREQ(N)) bus ();

    serial_add_sched #(.WIDTH(W), .NREQ(N)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
        end
    endfunction

    // Transaction model: one outstanding job, result ready W+1 negedges after the grant is seen.
    int         cyc = 0;
    bit         m_busy = 0;
    int         m_acc = 0;
    int         m_last = N - 1;
    int         m_id = 0;
    logic [W:0] m_res = '0;
    int         g_id[$];
    int         g_cyc[$];

    always @(negedge clk) begin
        logic [N-1:0] exp_ready;
        logic         exp_valid;
        logic [W:0]   ea, eb;
        int           pick;
        bit           s;
        cyc++;
        if (!rst_n) begin
            m_busy = 0;
            m_last = N - 1;
            chk("rst_rsp_valid", 64'(bus.rsp_valid), 64'(0));
            chk("rst_busy", 64'(bus.busy), 64'(0));
            chk("rst_rsp_sum", 64'(bus.rsp_sum), 64'(0));
            chk("rst_rsp_cout", 64'(bus.rsp_cout), 64'(0));
            chk("rst_rsp_id", 64'(bus.rsp_id), 64'(0));
        end else begin
            exp_ready = '0;
            pick = -1;
            if (!m_busy) begin
                for (int k = 1; k <= N; k++) begin
                    if (pick < 0 && bus.req_valid[(m_last + k) % N]) pick = (m_last + k) % N;
                end
                if (pick >= 0) exp_ready[pick] = 1'b1;
            end
            exp_valid = m_busy && (cyc >= m_acc + W + 1);
            chk("req_ready", 64'(bus.req_ready), 64'(exp_ready));
            chk("rsp_valid", 64'(bus.rsp_valid), 64'(exp_valid));
            chk("busy", 64'(bus.busy), 64'(m_busy));
            if (exp_valid) begin
                chk("rsp_sum", 64'(bus.rsp_sum), 64'(m_res[W-1:0]));
                chk("rsp_cout", 64'(bus.rsp_cout), 64'(m_res[W]));
                chk("rsp_id", 64'(bus.rsp_id), 64'(m_id));
            end
            if (exp_valid && bus.rsp_ready) begin
                m_busy = 0;
            end else if (pick >= 0) begin
                s = 0;
`ifdef SERIAL_ADD_SUB_EN
                s = bus.req_sub[pick];
`endif
                ea = {1'b0, bus.req_a[pick*W +: W]};
                eb = {1'b0, (s ? ~bus.req_b[pick*W +: W] : bus.req_b[pick*W +: W])};
                m_res  = ea + eb + (W+1)'(s);
                m_busy = 1;
                m_acc  = cyc;
                m_id   = pick;
                m_last = pick;
                g_id.push_back(pick);
                g_cyc.push_back(cyc);
            end
        end
    end

    task automatic set_sub(input int id, input bit s);
`ifdef SERIAL_ADD_SUB_EN
        bus.req_sub     = '0;
        bus.req_sub[id] = s;
`endif
    endtask

    task automatic drain();
        bus.req_valid = '0;
        bus.rsp_ready = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (!bus.busy) return;
        end
        chk("drain_timeout", 64'(bus.busy), 64'(0));
    endtask

    task automatic run_one(input int id, input logic [W-1:0] a, input logic [W-1:0] b, input bit s,
                           input logic [W-1:0] exp_sum, input bit exp_cout, input int hold);
        int n;
        @(posedge clk); #1;
        bus.req_valid = '0;
        bus.req_valid[id] = 1'b1;
        bus.req_a[id*W +: W] = a;
        bus.req_b[id*W +: W] = b;
        set_sub(id, s);
        bus.rsp_ready = (hold == 0);
        @(negedge clk);
        chk("dir_grant", 64'(bus.req_ready), 64'(1) << id);
        @(posedge clk); #1;
        bus.req_valid = '0;
        bus.req_a = {$urandom, $urandom};
        bus.req_b = {$urandom, $urandom};
        n = 1;
        while (n < 40) begin
            @(negedge clk);
            if (bus.rsp_valid) break;
            n++;
        end
        chk("dir_latency", 64'(n - 1), 64'(W));
        chk("dir_sum", 64'(bus.rsp_sum), 64'(exp_sum));
        chk("dir_cout", 64'(bus.rsp_cout), 64'(exp_cout));
        chk("dir_id", 64'(bus.rsp_id), 64'(id));
        if (hold > 0) begin
            bus.req_valid = '1;
            for (int i = 0; i < hold; i++) begin
                @(negedge clk);
                chk("bp_valid", 64'(bus.rsp_valid), 64'(1));
                chk("bp_sum", 64'(bus.rsp_sum), 64'(exp_sum));
                chk("bp_ready_zero", 64'(bus.req_ready), 64'(0));
            end
            @(posedge clk); #1;
            bus.req_valid = '0;
            bus.rsp_ready = 1'b1;
            @(posedge clk);
            @(negedge clk);
            chk("bp_valid_drop", 64'(bus.rsp_valid), 64'(0));
        end
        @(posedge clk); #1;
    endtask

    initial begin
        int st;
        bus.req_valid = '0;
        bus.req_a = '0;
        bus.req_b = '0;
        bus.rsp_ready = 1'b1;
        set_sub(0, 1'b0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        run_one(0, 8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, 0);
        run_one(2, 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 0);
        run_one(1, 8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 5);
        run_one(3, 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 0);
`ifdef SERIAL_ADD_SUB_EN
        run_one(0, 8'h10, 8'h20, 1'b1, 8'hF0, 1'b0, 0);
        run_one(3, 8'h20, 8'h10, 1'b1, 8'h10, 1'b1, 0);
`endif

        // Fairness from a fresh pointer.
        @(posedge clk); #1 rst_n = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
        set_sub(0, 1'b0);
        st = g_id.size();
        bus.req_valid = '1;
        bus.rsp_ready = 1'b1;
        for (int i = 0; i < 100 && g_id.size() < st + 5; i++) @(negedge clk);
        chk("fair_count", 64'(g_id.size() >= st + 5), 64'(1));
        if (g_id.size() >= st + 5) begin
            for (int i = 0; i < 5; i++) chk("fair_order", 64'(g_id[st+i]), 64'(i % N));
            for (int i = 1; i < 5; i++) chk("fair_spacing", 64'(g_cyc[st+i] - g_cyc[st+i-1]), 64'(W + 2));
        end
        @(posedge clk); #1;
        drain();

        // Reset in the middle of a shift, then pointer must be back at requester 0.
        @(posedge clk); #1;
        bus.req_valid = 4'b0010;
        @(negedge clk);
        chk("rs_grant1", 64'(bus.req_ready), 64'(4'b0010));
        repeat (5) @(posedge clk);
        #1 rst_n = 1'b0;
        bus.req_valid = '0;
        #1;
        chk("rs_valid0", 64'(bus.rsp_valid), 64'(0));
        chk("rs_busy0", 64'(bus.busy), 64'(0));
        chk("rs_sum0", 64'(bus.rsp_sum), 64'(0));
        chk("rs_ready0", 64'(bus.req_ready), 64'(0));
        @(posedge clk); #1;
        bus.req_valid = 4'b0011;
        rst_n = 1'b1;
        @(negedge clk);
        chk("rs_grant0", 64'(bus.req_ready), 64'(4'b0001));
        @(posedge clk); #1;
        drain();

        // Random traffic with occasional resets.
        for (int i = 0; i < 1500; i++) begin
            @(posedge clk); #1;
            rst_n = ($urandom_range(0, 299) != 0);
            bus.req_valid = N'($urandom);
            bus.req_a = {$urandom, $urandom};
            bus.req_b = {$urandom, $urandom};
`ifdef SERIAL_ADD_SUB_EN
            bus.req_sub = N'($urandom);
`endif
            bus.rsp_ready = ($urandom_range(0, 3) != 0);
        end
        @(posedge clk); #1 rst_n = 1'b1;
        drain();
        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule
